mse_accumulator: RTL and testbench

- Downstream stage of the DUT/reference FIR pair: consumes both FIR output streams and computes the mean squared error over a fixed window.
- Hands the 64-bit result and a valid flag to control_unit, which returns it over UART.
- One measurement per start pulse; a pipelined difference, square and accumulate datapath, sequenced by a small FSM.

---
 rtl/mse_pkg.sv | 19 +
 rtl/mse_sq_pipe.sv | 52 +++++
 rtl/mse_accumulator.sv | 137 +++++++++++++
 tb/tb_mse_accumulator.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/mse_pkg.sv
// Shared types and widths for the MSE accumulator: FSM state encoding and
// the default datapath widths derived from the FIR output word length.
package mse_pkg;

    localparam int DATA_WL_DEF  = 12;
    localparam int DIFF_WL      = DATA_WL_DEF + 1;
    localparam int SQ_WL        = 2 * DIFF_WL;
    localparam int ACC_WL       = 64;
    localparam int DRAIN_CYCLES = 2;

    typedef enum logic [2:0] {
        IDLE,
        FLUSH,
        ACCUM,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/mse_sq_pipe.sv
// Two-stage difference/square pipeline: signed difference of the two FIR
// streams, then its square, each stage carrying its own valid bit.
module mse_sq_pipe
    import mse_pkg::*;
#(
    parameter int DATA_WL = DATA_WL_DEF
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         vld_p0,
    input  logic signed [DATA_WL-1:0]    data_in,
    input  logic signed [DATA_WL-1:0]    data_ref,
    output logic [2*(DATA_WL+1)-1:0]     sq_p2,
    output logic                         vld_p2
);

    localparam int DIFF_W = DATA_WL + 1;
    localparam int SQ_W   = 2 * DIFF_W;

    logic signed [DIFF_W-1:0] diff_p1;
    logic                     vld_p1;
    logic signed [SQ_W-1:0]   diff_ext;
    logic signed [SQ_W-1:0]   sq_full;

    // Square is always non-negative and fits SQ_W bits, so the signed
    // product can be reinterpreted as unsigned without loss.
    assign diff_ext = SQ_W'(diff_p1);
    assign sq_full  = diff_ext * diff_ext;

    // stage p0 -> p1: widened difference
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            diff_p1 <= '0;
            vld_p1  <= 1'b0;
        end else begin
            diff_p1 <= DIFF_W'(data_in) - DIFF_W'(data_ref);
            vld_p1  <= vld_p0;
        end
    end

    // stage p1 -> p2: square
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sq_p2  <= '0;
            vld_p2 <= 1'b0;
        end else begin
            sq_p2  <= $unsigned(sq_full);
            vld_p2 <= vld_p1;
        end
    end

endmodule

// File: rtl/mse_accumulator.sv
// Mean squared error between DUT and reference FIR outputs over a window of
// 2^LOG2_N samples, taken after SETTLE flush cycles; one result per start.
module mse_accumulator
    import mse_pkg::*;
#(
    parameter int DATA_WL = DATA_WL_DEF,
    parameter int LOG2_N  = 16,
    parameter int SETTLE  = 32
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      start,
    input  logic signed [DATA_WL-1:0] data_in,
    input  logic signed [DATA_WL-1:0] data_ref,
    output logic [ACC_WL-1:0]         mse_data,
    output logic                      mse_valid,
    output logic                      busy
);

    localparam int SQ_W      = 2 * (DATA_WL + 1);
    localparam int N_SAMPLES = 2 ** LOG2_N;
    localparam int CNT_MAX_A = (SETTLE > N_SAMPLES) ? SETTLE : N_SAMPLES;
    localparam int CNT_MAX   = (CNT_MAX_A > DRAIN_CYCLES) ? CNT_MAX_A : DRAIN_CYCLES;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'((SETTLE > 0) ? SETTLE - 1 : 0);
    localparam logic [CNT_W-1:0] ACCUM_LAST  = CNT_W'(N_SAMPLES - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST  = CNT_W'(DRAIN_CYCLES);
    localparam state_t           START_STATE = (SETTLE > 0) ? FLUSH : ACCUM;

    function automatic logic [ACC_WL-1:0] sat_add(input logic [ACC_WL-1:0] a,
                                                  input logic [SQ_W-1:0]   b);
        logic [ACC_WL:0] sum;
        sum = {1'b0, a} + (ACC_WL+1)'(b);
        return sum[ACC_WL] ? '1 : sum[ACC_WL-1:0];
    endfunction

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               acc_clr;
    logic               res_load;
    logic               vld_p0;
    logic [SQ_W-1:0]    sq_p2;
    logic               vld_p2;
    logic [ACC_WL-1:0]  acc_q;

    assign vld_p0    = (state_q == ACCUM);
    assign mse_valid = (state_q == DONE);
    assign busy      = (state_q == FLUSH) || (state_q == ACCUM) || (state_q == DRAIN);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // DRAIN holds until the last square has landed in acc, so the result
    // is loaded from a settled accumulator on the DRAIN -> DONE edge.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_clr  = 1'b0;
        res_load = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = START_STATE;
                    cnt_d   = '0;
                    acc_clr = 1'b1;
                end
            end
            FLUSH: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = ACCUM;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ACCUM: begin
                if (cnt_q == ACCUM_LAST) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DRAIN: begin
                if (cnt_q == DRAIN_LAST) begin
                    state_d  = DONE;
                    cnt_d    = '0;
                    res_load = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    mse_sq_pipe #(
        .DATA_WL (DATA_WL)
    ) u_sq_pipe (
        .clk      (clk),
        .rstn     (rstn),
        .vld_p0   (vld_p0),
        .data_in  (data_in),
        .data_ref (data_ref),
        .sq_p2    (sq_p2),
        .vld_p2   (vld_p2)
    );

    // stage p2 -> accumulator and result register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc_q    <= '0;
            mse_data <= '0;
        end else begin
            if (acc_clr) begin
                acc_q <= '0;
            end else if (vld_p2) begin
                acc_q <= sat_add(acc_q, sq_p2);
            end
            if (res_load) begin
                mse_data <= acc_q >> LOG2_N;
            end
        end
    end

endmodule

// File: tb/tb_mse_accumulator.sv
// Directed bench for mse_accumulator at DATA_WL=12, LOG2_N=4, SETTLE=3:
// table of constant-input measurements plus hand-written multi-cycle cases.
module tb_mse_accumulator;

    logic                clk = 1'b0;
    logic                rstn;
    logic                start;
    logic signed [11:0]  data_in;
    logic signed [11:0]  data_ref;
    logic [63:0]         mse_data;
    logic                mse_valid;
    logic                busy;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    localparam int M_CONST  = 0;
    localparam int M_ALT    = 1;
    localparam int M_SETTLE = 2;
    localparam int EXP_LAT  = 22;

    typedef struct {
        logic signed [11:0] di;
        logic signed [11:0] dr;
        logic [63:0]        exp_mse;
    } vec_t;

    vec_t vecs [4];

    always #5 clk = ~clk;

    mse_accumulator #(
        .DATA_WL (12),
        .LOG2_N  (4),
        .SETTLE  (3)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .data_in   (data_in),
        .data_ref  (data_ref),
        .mse_data  (mse_data),
        .mse_valid (mse_valid),
        .busy      (busy)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Data presented for capture at edge e (edge 0 = start sampled).
    // The window is edges 4..19; outside it the data is deliberately large.
    task automatic drive_for_edge(input int e, input int mode,
                                  input logic signed [11:0] di,
                                  input logic signed [11:0] dr);
        case (mode)
            M_ALT: begin
                data_ref = 12'sd0;
                if (e >= 4 && e <= 19) data_in = (((e - 4) % 2) == 0) ? 12'sd1 : 12'sd2;
                else data_in = 12'sd50;
            end
            M_SETTLE: begin
                data_ref = 12'sd0;
                data_in  = (e >= 4 && e <= 19) ? 12'sd0 : 12'sd1000;
            end
            default: begin
                data_in  = di;
                data_ref = dr;
            end
        endcase
    endtask

    task automatic run_meas(input string nm, input int mode,
                            input logic signed [11:0] di,
                            input logic signed [11:0] dr,
                            input logic [63:0] exp_mse, input bit ign);
        int          vt;
        bit          had_valid;
        logic [63:0] old;
        had_valid = mse_valid;
        old       = mse_data;
        vt        = -1;
        start     = 1'b1;
        drive_for_edge(0, mode, di, dr);
        tick();
        start = 1'b0;
        for (int t = 0; t < 40 && vt < 0; t++) begin
            drive_for_edge(t + 1, mode, di, dr);
            start = ign && (t == 1 || t == 10 || t == 20);
            tick();
            if (t == 0) begin
                check({nm, " busy@1"}, busy, 1);
                check({nm, " valid@1"}, mse_valid, 0);
                if (had_valid) check({nm, " old data held"}, mse_data, old);
            end
            if (mse_valid) vt = t + 1;
        end
        start = 1'b0;
        check({nm, " latency"}, vt, EXP_LAT);
        check({nm, " mse_data"}, mse_data, exp_mse);
        check({nm, " busy done"}, busy, 0);
        repeat (3) tick();
        check({nm, " valid hold"}, mse_valid, 1);
        check({nm, " data hold"}, mse_data, exp_mse);
    endtask

    initial begin
        vecs[0] = '{12'sd100,  12'sd100,  64'd0};
        vecs[1] = '{12'sd5,    12'sd2,    64'd9};
        vecs[2] = '{12'sd2047, 12'h800,   64'd16769025};
        vecs[3] = '{-12'sd7,   12'sd8,    64'd225};

        rstn     = 1'b0;
        start    = 1'b0;
        data_in  = 12'sd0;
        data_ref = 12'sd0;
        repeat (3) @(negedge clk);
        check("reset mse_valid", mse_valid, 0);
        check("reset mse_data", mse_data, 0);
        check("reset busy", busy, 0);
        rstn = 1'b1;
        tick();
        check("idle busy", busy, 0);

        for (int i = 0; i < 4; i++) begin
            run_meas($sformatf("vec%0d", i), M_CONST, vecs[i].di, vecs[i].dr,
                     vecs[i].exp_mse, 1'b0);
        end

        // diffs 1,2,1,2...: sum 40, 40>>4 truncates to 2
        run_meas("alternating", M_ALT, 12'sd0, 12'sd0, 64'd2, 1'b0);
        run_meas("settle excl", M_SETTLE, 12'sd0, 12'sd0, 64'd0, 1'b0);
        run_meas("ignored start", M_CONST, 12'sd5, 12'sd2, 64'd9, 1'b1);
        run_meas("start in done", M_CONST, 12'sd3, 12'sd0, 64'd9, 1'b0);

        // reset abort mid-ACCUM
        start    = 1'b1;
        data_in  = 12'sd100;
        data_ref = 12'sd0;
        tick();
        start = 1'b0;
        repeat (10) tick();
        check("abort busy before", busy, 1);
        rstn = 1'b0;
        #1;
        check("abort mse_valid", mse_valid, 0);
        check("abort mse_data", mse_data, 0);
        check("abort busy", busy, 0);
        @(negedge clk);
        rstn = 1'b1;
        tick();
        run_meas("after abort", M_CONST, 12'sd6, 12'sd0, 64'd36, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
